// File: rtl/portfolio_valuator.sv
// Portfolio valuator: holds a signed fixed-point weight vector and values each
// accepted price snapshot as sum(weight[i] * price[i]) using one shared
// multiplier (one product per cycle), then rounds and saturates the result.
module portfolio_valuator #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned N_STOCKS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_weights,
    input  logic [N_STOCKS*WIDTH-1:0]    weights,
    output logic                         weights_loaded,
    input  logic                         price_valid,
    input  logic [N_STOCKS*WIDTH-1:0]    prices,
    output logic                         price_ready,
    output logic                         value_valid,
    output logic [WIDTH-1:0]             value,
    input  logic                         value_ready,
    output logic                         overflow
);

    // Accumulator is wide enough that N_STOCKS full-precision products never wrap.
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N_STOCKS) + 1;
    localparam int unsigned IDX_W = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STOCKS - 1);

    // Rounding constant 2^(FRAC-1); FRAC is assumed to be at least 1.
    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

    state_e                   state_q;
    logic signed [WIDTH-1:0]  weight_q [N_STOCKS];
    logic signed [WIDTH-1:0]  price_q  [N_STOCKS];
    logic signed [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]         idx_q;

    logic signed [2*WIDTH-1:0] product;
    logic signed [ACC_W-1:0]   product_ext;
    logic signed [ACC_W-1:0]   rounded;
    logic [WIDTH-1:0]          value_d;
    logic                      overflow_d;

    // A pending weight load wins over a price handshake in the same cycle.
    assign price_ready = (state_q == StIdle) && weights_loaded && !load_weights;

    // Shared multiplier, sign extension into the accumulator, and round/saturate.
    always_comb begin
        product     = weight_q[idx_q] * price_q[idx_q];
        product_ext = {{(ACC_W-2*WIDTH){product[2*WIDTH-1]}}, product};
        rounded     = (acc_q + HALF) >>> FRAC;
        value_d     = rounded[WIDTH-1:0];
        overflow_d  = 1'b0;
        if (rounded > SAT_MAX) begin
            value_d    = {1'b0, {(WIDTH-1){1'b1}}};
            overflow_d = 1'b1;
        end else if (rounded < SAT_MIN) begin
            value_d    = {1'b1, {(WIDTH-1){1'b0}}};
            overflow_d = 1'b1;
        end
    end

    // Control FSM with registered outputs; reset discards any in-flight snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            idx_q          <= '0;
            weights_loaded <= 1'b0;
            value_valid    <= 1'b0;
            value          <= '0;
            overflow       <= 1'b0;
            for (int i = 0; i < N_STOCKS; i++) begin
                weight_q[i] <= '0;
                price_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_weights) begin
                        for (int i = 0; i < N_STOCKS; i++) begin
                            weight_q[i] <= weights[i*WIDTH +: WIDTH];
                        end
                        weights_loaded <= 1'b1;
                    end else if (price_valid && price_ready) begin
                        for (int i = 0; i < N_STOCKS; i++) begin
                            price_q[i] <= prices[i*WIDTH +: WIDTH];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + product_ext;
                    if (idx_q == LAST_IDX) begin
                        state_q <= StRound;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StRound: begin
                    value       <= value_d;
                    overflow    <= overflow_d;
                    value_valid <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (value_ready) begin
                        value_valid <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_portfolio_valuator.sv
// Directed testbench for portfolio_valuator with hand-computed Q7.8 results.
module tb_portfolio_valuator;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned FRAC     = 8;
    localparam int unsigned N_STOCKS = 3;

    logic                      clk;
    logic                      rst;
    logic                      load_weights;
    logic [N_STOCKS*WIDTH-1:0] weights;
    logic                      weights_loaded;
    logic                      price_valid;
    logic [N_STOCKS*WIDTH-1:0] prices;
    logic                      price_ready;
    logic                      value_valid;
    logic [WIDTH-1:0]          value;
    logic                      value_ready;
    logic                      overflow;

    int total = 0;
    int bad   = 0;

    portfolio_valuator #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .N_STOCKS (N_STOCKS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_weights   (load_weights),
        .weights        (weights),
        .weights_loaded (weights_loaded),
        .price_valid    (price_valid),
        .prices         (prices),
        .price_ready    (price_ready),
        .value_valid    (value_valid),
        .value          (value),
        .value_ready    (value_ready),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Element 0 lands in the low bits.
    function automatic logic [N_STOCKS*WIDTH-1:0] vec3(input logic [15:0] a,
                                                       input logic [15:0] b,
                                                       input logic [15:0] c);
        return {c, b, a};
    endfunction

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N_STOCKS*WIDTH-1:0] w);
        load_weights = 1'b1;
        weights      = w;
        tick();
        load_weights = 1'b0;
    endtask

    // Offer a snapshot, check latency from the accept edge, value and overflow, then hand off.
    task automatic run_snapshot(input string tag, input logic [N_STOCKS*WIDTH-1:0] p,
                                input logic [15:0] exp_val, input logic exp_ovf);
        int n;
        int lat;
        price_valid = 1'b1;
        prices      = p;
        #1;
        n = 0;
        while (!price_ready && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(price_ready), 32'd1);
        tick();
        price_valid = 1'b0;
        lat = 1;
        while (!value_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_val"}, 32'(value), 32'(exp_val));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        value_ready = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(value_valid), 32'd0);
    endtask

    logic [N_STOCKS*WIDTH-1:0] w_basic;
    logic [N_STOCKS*WIDTH-1:0] p_basic;
    logic [N_STOCKS*WIDTH-1:0] w_ones;

    initial begin
        int n;
        logic [15:0] held_val;
        w_basic = vec3(16'h0080, 16'h0040, 16'h0040);
        p_basic = vec3(16'h0A00, 16'h1400, 16'h2800);
        w_ones  = vec3(16'h0100, 16'h0100, 16'h0100);

        rst          = 1'b1;
        load_weights = 1'b0;
        weights      = '0;
        price_valid  = 1'b0;
        prices       = '0;
        value_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_loaded", 32'(weights_loaded), 32'd0);
        chk("rst_pready", 32'(price_ready), 32'd0);
        chk("rst_vvalid", 32'(value_valid), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Basic: 0.5*10 + 0.25*20 + 0.25*40 = 20.0
        load(w_basic);
        chk("basic_loaded", 32'(weights_loaded), 32'd1);
        run_snapshot("basic", p_basic, 16'h1400, 1'b0);

        // Signed: 1*3 - 1*5 + 0*7 = -2.0
        load(vec3(16'h0100, 16'hFF00, 16'h0000));
        run_snapshot("signed", vec3(16'h0300, 16'h0500, 16'h0700), 16'hFE00, 1'b0);

        // Saturation both ways: +/-3 * 127.0
        load(w_ones);
        run_snapshot("sat_pos", vec3(16'h7F00, 16'h7F00, 16'h7F00), 16'h7FFF, 1'b1);
        load(vec3(16'hFF00, 16'hFF00, 16'hFF00));
        run_snapshot("sat_neg", vec3(16'h7F00, 16'h7F00, 16'h7F00), 16'h8000, 1'b1);

        // Rounding: +128 rounds up to 1; -128 rounds half toward +inf to 0
        load(vec3(16'h0001, 16'h0000, 16'h0000));
        run_snapshot("rnd_pos", vec3(16'h0080, 16'h0000, 16'h0000), 16'h0001, 1'b0);
        load(vec3(16'hFFFF, 16'h0000, 16'h0000));
        run_snapshot("rnd_neg", vec3(16'h0080, 16'h0000, 16'h0000), 16'h0000, 1'b0);

        // Backpressure plus a load_weights pulse during MAC that must be ignored
        load(w_basic);
        value_ready = 1'b0;
        price_valid = 1'b1;
        prices      = p_basic;
        #1;
        chk("bp_ready", 32'(price_ready), 32'd1);
        tick();
        price_valid  = 1'b0;
        load_weights = 1'b1;
        weights      = w_ones;
        tick();
        load_weights = 1'b0;
        chk("bp_loaded", 32'(weights_loaded), 32'd1);
        n = 0;
        while (!value_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_valid", 32'(value_valid), 32'd1);
        chk("bp_val", 32'(value), 32'h1400);
        held_val    = value;
        price_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_val", 32'(value), 32'(held_val));
            chk("bp_hold_ovf", 32'(overflow), 32'd0);
            chk("bp_hold_vv", 32'(value_valid), 32'd1);
            chk("bp_hold_pr", 32'(price_ready), 32'd0);
        end
        price_valid = 1'b0;
        value_ready = 1'b1;
        tick();
        chk("bp_released", 32'(value_valid), 32'd0);

        // Next snapshot still uses the old weights
        run_snapshot("old_w", p_basic, 16'h1400, 1'b0);

        // Load concurrent with a price offer: load wins, snapshot goes next cycle
        load_weights = 1'b1;
        weights      = w_ones;
        price_valid  = 1'b1;
        prices       = p_basic;
        #1;
        chk("conc_pready", 32'(price_ready), 32'd0);
        tick();
        load_weights = 1'b0;
        #1;
        chk("conc_pready2", 32'(price_ready), 32'd1);
        run_snapshot("new_w", p_basic, 16'h4600, 1'b0);

        // Reset during the second MAC cycle
        load(w_basic);
        price_valid = 1'b1;
        prices      = p_basic;
        tick();
        price_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_loaded", 32'(weights_loaded), 32'd0);
        chk("mrst_pready", 32'(price_ready), 32'd0);
        chk("mrst_vvalid", 32'(value_valid), 32'd0);
        chk("mrst_value", 32'(value), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        price_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mrst_pr", 32'(price_ready), 32'd0);
            chk("mrst_vv", 32'(value_valid), 32'd0);
        end
        price_valid = 1'b0;
        load(w_basic);
        run_snapshot("recover", p_basic, 16'h1400, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/portfolio_valuator.md
# portfolio_valuator

Consumer of the normalized eigenportfolio weight vector. Latches N_STOCKS signed fixed-point weights, then values each incoming price snapshot as the dot product Σ weight[i]·price[i]. It uses a single shared multiplier, one product per cycle. The rounded, saturated portfolio value is returned through a valid/ready output for the downstream spread/signal logic.

## Interface
- WIDTH, 16, bit width of every weight, price and value (signed two's complement)
- FRAC, 8, fractional bits of the shared fixed-point format (Q7.8 at defaults)
- N_STOCKS, 3, number of assets in the weight and price vectors
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_weights  in  1  one-cycle request to latch `weights`
- weights  in  N_STOCKS×WIDTH  signed weights; element i is the weight of stock i
- weights_loaded  out  1  high once a weight set is held
- price_valid  in  1  price snapshot offered
- prices  in  N_STOCKS×WIDTH  signed prices, same format as weights
- price_ready  out  1  snapshot accepted on a clock edge where price_valid && price_ready
- value_valid  out  1  result available
- value  out  WIDTH  signed portfolio value, FRAC fractional bits
- value_ready  in  1  downstream accepts result
- overflow  out  1  result was saturated; valid with value_valid

## Operation
- FSM states and transitions:
  - IDLE: on accept → MAC.
  - MAC: runs N_STOCKS cycles, idx 0..N_STOCKS-1, then → ROUND.
  - ROUND: one cycle, then → OUT.
  - OUT: on value_valid && value_ready → IDLE.
- Weight load:
  - Honoured only in IDLE. Copies all weights and sets weights_loaded.
  - Ignored in any other state; an in-flight computation always uses the weights held at accept.
- price_ready = (state==IDLE) && weights_loaded && !load_weights. It is combinational. A simultaneous load_weights takes priority over a price handshake.
- On accept, prices are registered; the accumulator clears to 0.
- MAC: acc += weights[idx]·prices[idx]. Full-precision signed product of 2·WIDTH bits. Accumulator is 2·WIDTH+$clog2(N_STOCKS)+1 bits and never wraps.
- ROUND:
  - r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half toward +∞).
  - If r > 2^(WIDTH-1)-1, value = 0x7FF…F; if r < -2^(WIDTH-1), value = 0x800…0. In either case overflow=1.
  - Otherwise value = r[WIDTH-1:0] and overflow=0.
- OUT: value_valid=1. value and overflow stay stable until the handshake. No new snapshot is accepted while in OUT.
- Reset mid-operation: the in-flight snapshot is discarded, all state is cleared, and weights must be reloaded.

## Timing
- Reset values:
  - state=IDLE.
  - weights_loaded=0, price_ready=0.
  - value_valid=0, value=0, overflow=0.
  - Internal weights and accumulator are 0.
- A load_weights pulse at edge T gives weights_loaded=1 after T. price_ready can rise in the cycle after T.
- Snapshot accepted at edge T:
  - MAC edges are T+1…T+N_STOCKS.
  - ROUND edge is T+N_STOCKS+1.
  - value_valid=1 after that edge, i.e. latency N_STOCKS+2 cycles (5 at defaults).
- A handshake at edge H takes the FSM to IDLE, so price_ready can be high in the cycle after H. Steady-state throughput is one result per N_STOCKS+3 cycles with value_ready tied high.
- value_ready held low stalls the FSM in OUT indefinitely with no loss or change of data.

## Test plan
- Basic: weights {0x0080,0x0040,0x0040} (0.5, 0.25, 0.25), prices {0x0A00,0x1400,0x2800} (10, 20, 40). Required: value=0x1400 (20.0), overflow=0, value_valid exactly 5 cycles after accept.
- Signed: weights {0x0100,0xFF00,0x0000}, prices {0x0300,0x0500,0x0700}. Required: value=0xFE00 (−2.0), overflow=0.
- Saturation: weights all 0x0100, prices all 0x7F00. Required: value=0x7FFF, overflow=1. Then weights all 0xFF00 with the same prices. Required: value=0x8000, overflow=1.
- Rounding: weights {0x0001,0,0}, prices {0x0080,0,0}. Required: value=0x0001. Repeat with weight 0xFFFF. Required: value=0x0000.
- Backpressure and ignored load:
  - Hold value_ready low for 10 cycles. Required: value/overflow stable, price_ready=0.
  - Pulse load_weights with new weights during MAC. Required: the current result is unaffected and weights_loaded stays 1.
  - Run the next snapshot. Required: it uses the old weights.
  - load_weights concurrent with price_valid in IDLE. Required: price_ready=0 that cycle; the snapshot is accepted the following cycle using the new weights.
- Reset: assert rst during the 2nd MAC cycle. Required: after that edge, all outputs are 0 and weights_loaded=0. price_valid is not accepted until weights are reloaded.
